z80_io_strobe: RTL

Synchronous Z80 I/O cycle decoder in the CPLD, directly upstream of the memory mapper page registers. Resamples the raw Z80 bus strobes (IORQ, RD, WR, M1) into the CLK_24MHz domain, qualifies them against glitches, and emits one-cycle write/read strobes with latched port address and write data. The mapper and any future port consumers (e.g. 16550 chip-select logic) decode `io_addr` on `io_wr_stb` instead of clocking registers from the asynchronous `IORQ|WR` edge.

---
 rtl/z80bd_pkg.sv | 41 ++++
 rtl/z80_io_strobe_if.sv | 28 ++
 rtl/z80_sync.sv | 19 +
 rtl/z80_io_strobe.sv | 108 ++++++++++
 4 files changed

// File: rtl/z80bd_pkg.sv
// Shared encodings for the Z80 bus decoder: FSM states, cycle types, mapper ports.
// Z80_IO_INTACK_EN enables decoding of interrupt-acknowledge cycles.
package z80bd_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_QUAL = 2'd1;
  localparam logic [1:0] S_FIRE = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  typedef enum logic [1:0] {
    CYC_NONE = 2'd0,
    CYC_WR   = 2'd1,
    CYC_RD   = 2'd2,
    CYC_INTA = 2'd3
  } cyc_t;

  localparam logic [7:0] MMAP_PORT0 = 8'h10;
  localparam logic [7:0] MMAP_PORT1 = 8'h11;
  localparam logic [7:0] MMAP_PORT2 = 8'h12;
  localparam logic [7:0] MMAP_PORT3 = 8'h13;

  // Active-low strobe levels in; WR wins over RD when both are low.
  function automatic cyc_t decode_cyc(input logic iorq, input logic rd,
                                      input logic wr, input logic m1);
    cyc_t c;
    c = CYC_NONE;
    if (!iorq) begin
      if (!m1) begin
`ifdef Z80_IO_INTACK_EN
        c = CYC_INTA;
`endif
      end else if (!wr) begin
        c = CYC_WR;
      end else if (!rd) begin
        c = CYC_RD;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/z80_io_strobe_if.sv
// Z80 bus side and qualified-strobe side of the I/O decoder.
// intack_stb exists only when Z80_IO_INTACK_EN is defined.
interface z80_io_strobe_if;
  logic       IORQ, RD, WR, M1;
  logic [7:0] A, D;
  logic       io_wr_stb, io_rd_stb;
  logic [7:0] io_addr, io_wdata;
  logic       io_busy;
`ifdef Z80_IO_INTACK_EN
  logic       intack_stb;
`endif

  modport master (
`ifdef Z80_IO_INTACK_EN
    input  intack_stb,
`endif
    output IORQ, RD, WR, M1, A, D,
    input  io_wr_stb, io_rd_stb, io_addr, io_wdata, io_busy
  );

  modport slave (
`ifdef Z80_IO_INTACK_EN
    output intack_stb,
`endif
    input  IORQ, RD, WR, M1, A, D,
    output io_wr_stb, io_rd_stb, io_addr, io_wdata, io_busy
  );
endinterface

// File: rtl/z80_sync.sv
// N-stage synchronizer for active-low strobes; resets to all-ones (inactive).
module z80_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES-1:0][WIDTH-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= '1;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];
endmodule

// File: rtl/z80_io_strobe.sv
// Qualifies resampled Z80 I/O cycles and emits one-clock strobes with latched addr/data.
// Z80_IO_INTACK_EN adds interrupt-acknowledge qualification and intack_stb.
module z80_io_strobe
  import z80bd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int QUAL_CYCLES = 2
) (
  input logic            CLK_24MHz,
  input logic            RES,
  z80_io_strobe_if.slave bus
);
  localparam int             CW  = $clog2(QUAL_CYCLES + 1);
  localparam logic [CW-1:0]  QC  = CW'(QUAL_CYCLES);
  localparam logic [CW-1:0]  ONE = CW'(1);

  logic [3:0]             sync_q;
  logic                   iorq_s, rd_s, wr_s, m1_s;
  cyc_t                   cyc_now, cyc_lat;
  logic [1:0]             state;
  logic [CW-1:0]          cnt, cnt_inc;
  logic [SYNC_STAGES-1:0] flush_pipe;
  logic                   armed;
  logic                   wr_stb, rd_stb;
  logic [7:0]             addr_q, wdata_q;
`ifdef Z80_IO_INTACK_EN
  logic                   inta_stb;
`endif

  z80_sync #(.WIDTH(4), .STAGES(SYNC_STAGES)) u_sync (
    .clk (CLK_24MHz),
    .rst (RES),
    .d   ({bus.IORQ, bus.RD, bus.WR, bus.M1}),
    .q   (sync_q)
  );

  assign {iorq_s, rd_s, wr_s, m1_s} = sync_q;
  assign cyc_now = decode_cyc(iorq_s, rd_s, wr_s, m1_s);
  assign cnt_inc = cnt + ONE;

  // The synchronizer's reset ones are not real bus samples; armed waits until the
  // flushed chain shows IORQ released, so a cycle spanning reset release is skipped.
  always_ff @(posedge CLK_24MHz) begin
    if (RES) begin
      state      <= S_IDLE;
      cnt        <= '0;
      cyc_lat    <= CYC_NONE;
      flush_pipe <= '0;
      armed      <= 1'b0;
      wr_stb     <= 1'b0;
      rd_stb     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef Z80_IO_INTACK_EN
      inta_stb   <= 1'b0;
`endif
    end else begin
      flush_pipe <= {flush_pipe[SYNC_STAGES-2:0], 1'b1};
      armed      <= armed | (flush_pipe[SYNC_STAGES-1] & iorq_s);
      wr_stb     <= 1'b0;
      rd_stb     <= 1'b0;
`ifdef Z80_IO_INTACK_EN
      inta_stb   <= 1'b0;
`endif
      case (state)
        S_IDLE: if (armed && cyc_now != CYC_NONE) begin
          cyc_lat <= cyc_now;
          cnt     <= ONE;
          state   <= (QC <= ONE) ? S_FIRE : S_QUAL;
        end
        S_QUAL: if (cyc_now == cyc_lat) begin
          cnt <= cnt_inc;
          if (cnt_inc >= QC) state <= S_FIRE;
        end else begin
          cnt   <= '0;
          state <= S_IDLE;
        end
        S_FIRE: begin
          addr_q <= bus.A;
          case (cyc_lat)
            CYC_WR: begin
              wdata_q <= bus.D;
              wr_stb  <= 1'b1;
            end
            CYC_RD:   rd_stb   <= 1'b1;
`ifdef Z80_IO_INTACK_EN
            CYC_INTA: inta_stb <= 1'b1;
`endif
            default: ;
          endcase
          cnt   <= '0;
          state <= S_HOLD;
        end
        S_HOLD: if (iorq_s) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.io_wr_stb  = wr_stb;
  assign bus.io_rd_stb  = rd_stb;
  assign bus.io_addr    = addr_q;
  assign bus.io_wdata   = wdata_q;
  assign bus.io_busy    = (state != S_IDLE);
`ifdef Z80_IO_INTACK_EN
  assign bus.intack_stb = inta_stb;
`endif
endmodule
